// File: rtl/affine_store_arb.sv
// Round-robin arbiter and burst sequencer sharing one affine_store weight-streaming unit.
// It turns the store's addr/valid stream into slot-relative RAM write strobes.
// It re-arms the store between bursts and flags protocol errors.
module affine_store_arb #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned WORDS   = 64,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              st_load,
  input  logic              st_valid,
  input  logic [8:0]        st_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              err
);

  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned AW   = $clog2(WORDS);
  localparam int unsigned CMAX = (TIMEOUT > WORDS) ? TIMEOUT : WORDS;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBurst = 2'd1;
  localparam logic [1:0] StRearm = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic            primed_q, primed_d;
  logic [CW-1:0]   beats_q, beats_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic            abort_q, abort_d;
  logic            err_q, err_d;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;

  // Only the slot-relative low address bits matter; the rest of the store address is ignored.
  logic unused_st_addr;
  assign unused_st_addr = ^st_addr[8:AW];

  // Round-robin pick: first set request at or after rr_q, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      cand = IW'((int'(rr_q) + i) % int'(NREQ));
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Outputs decoded from registered state; st_load falls the instant reset asserts.
  always_comb begin
    st_load  = (state_q == StBurst);
    mem_we   = st_load & primed_q & ~st_valid;
    mem_addr = mem_we ? (ADDR_W'(idx_q) * ADDR_W'(WORDS) + ADDR_W'(st_addr[AW-1:0])) : '0;
    done     = (state_q == StRearm && !abort_q) ? grant_q : '0;
    grant    = grant_q;
    err      = err_q;
  end

  // Next-state logic for the IDLE -> BURST -> REARM sequence.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    rr_d     = rr_q;
    primed_d = primed_q;
    beats_d  = beats_q;
    cyc_d    = cyc_q;
    abort_d  = abort_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d  = StBurst;
          grant_d  = NREQ'(1) << pick_idx;
          idx_d    = pick_idx;
          primed_d = 1'b0;
          beats_d  = '0;
          cyc_d    = '0;
          abort_d  = 1'b0;
        end
      end
      StBurst: begin
        // The first load edge only initialises the store, so writes start one cycle in.
        primed_d = 1'b1;
        cyc_d    = cyc_q + 1'b1;
        if (mem_we) beats_d = beats_q + 1'b1;
        if (st_valid) begin
          state_d = StRearm;
          if (beats_q != CW'(WORDS)) err_d = 1'b1;
        end else if (!req[idx_q]) begin
          state_d = StRearm;
          abort_d = 1'b1;
        end else if (cyc_q == CW'(TIMEOUT - 1)) begin
          // Watchdog fires in the TIMEOUT-th BURST cycle.
          state_d = StRearm;
          abort_d = 1'b1;
          err_d   = 1'b1;
        end
      end
      StRearm: begin
        state_d  = StIdle;
        grant_d  = '0;
        primed_d = 1'b0;
        beats_d  = '0;
        cyc_d    = '0;
        abort_d  = 1'b0;
        rr_d     = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_q     <= '0;
      primed_q <= 1'b0;
      beats_q  <= '0;
      cyc_q    <= '0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      primed_q <= primed_d;
      beats_q  <= beats_d;
      cyc_q    <= cyc_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_affine_store_arb.sv
// Self-checking bench for affine_store_arb: vector table of bursts, directed abort and
// async-reset sequences, and a randomized run against a phase-based reference model.
module tb_affine_store_arb;

  localparam int NREQ    = 2;
  localparam int WORDS   = 64;
  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 80;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              st_load;
  logic              st_valid;
  logic [8:0]        st_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              err;

  int n_cmp  = 0;
  int n_fail = 0;

  affine_store_arb #(
    .NREQ    (NREQ),
    .WORDS   (WORDS),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant    (grant),
    .done     (done),
    .st_load  (st_load),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Store unit model: first load edge initialises, then the address walks until the word
  // count set by valid_at is reached (valid_at == 0 means valid never rises).
  int       valid_at  = 64;
  logic [8:0] s_addr  = '0;
  logic     s_valid   = 1'b0;
  logic     s_started = 1'b0;
  assign st_addr  = s_addr;
  assign st_valid = s_valid;

  always @(posedge clk) begin
    if (!st_load) begin
      s_addr    <= '0;
      s_valid   <= 1'b0;
      s_started <= 1'b0;
    end else if (!s_started) begin
      s_started <= 1'b1;
      s_addr    <= '0;
    end else if (!s_valid) begin
      if (valid_at != 0 && int'(s_addr) == valid_at - 1) s_valid <= 1'b1;
      else s_addr <= s_addr + 9'd1;
    end
  end

  typedef struct {
    logic [1:0] req;
    int         valid_at;
    logic [1:0] grant;
    int         base;
    logic [1:0] done;
    logic       err;
    int         rearm;
    int         beats;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_grant", grant, 0);
    chk("rst_st_load", st_load, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Called in an idle cycle; raises req and follows one burst through REARM back to IDLE.
  task automatic run_burst(input vec_t v);
    int beats;
    bit seen;
    beats    = 0;
    seen     = 1'b0;
    valid_at = v.valid_at;
    req      = v.req;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        chk("grant", grant, v.grant);
        chk("st_load_on", st_load, 1);
      end
      if (mem_we) begin
        chk("mem_addr", mem_addr, v.base + (beats % WORDS));
        beats++;
      end
      if (k > 1 && !st_load) begin
        seen = 1'b1;
        chk("rearm_cycle", k, v.rearm);
        chk("done", done, v.done);
        chk("err", err, v.err);
        req = '0;
      end else if (done != 0) begin
        chk("early_done", done, 0);
      end
    end
    if (!seen) chk("burst_bound", 0, 1);
    chk("beats", beats, v.beats);
    @(posedge clk); #1;
    chk("idle_grant", grant, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         beats;
    bit         dropped;
    int         ph;
    int         owner;
    int         rr;
    int         j;
    bit         found;
    logic [1:0] e_grant;
    logic [1:0] e_done;
    logic       e_load;
    logic       e_we;
    int         e_addr;
    vec_t       v;

    //          req    vat gnt    base done   err  rearm beats
    tbl[0] = '{2'b01, 64, 2'b01,  0, 2'b01, 1'b0, 67, 64};
    tbl[1] = '{2'b11, 64, 2'b10, 64, 2'b10, 1'b0, 67, 64};
    tbl[2] = '{2'b11, 64, 2'b01,  0, 2'b01, 1'b0, 67, 64};
    tbl[3] = '{2'b01, 64, 2'b01,  0, 2'b01, 1'b0, 67, 64};
    tbl[4] = '{2'b10, 40, 2'b10, 64, 2'b10, 1'b1, 43, 40};  // short burst
    tbl[5] = '{2'b11, 64, 2'b01,  0, 2'b01, 1'b1, 67, 64};  // err stays sticky
    tbl[6] = '{2'b10,  0, 2'b10, 64, 2'b00, 1'b1, 81, 79};  // watchdog

    do_reset();
    for (int i = 0; i < 7; i++) run_burst(tbl[i]);

    // Abort: owner drops req right after beat 10 is written.
    do_reset();
    valid_at = 64;
    req      = 2'b01;
    beats    = 0;
    dropped  = 1'b0;
    for (int k = 1; k <= 100 && !dropped; k++) begin
      @(posedge clk); #1;
      if (mem_we) beats++;
      if (beats == 11) begin
        req     = '0;
        dropped = 1'b1;
      end
    end
    chk("abort_reached", dropped, 1);
    @(posedge clk); #1;
    chk("abort_st_load", st_load, 0);
    chk("abort_mem_we", mem_we, 0);
    chk("abort_done", done, 0);
    @(posedge clk); #1;
    chk("abort_idle", grant, 0);
    chk("abort_err", err, 0);
    run_burst(tbl[0]);

    // Async reset at beat 30, between clock edges.
    do_reset();
    valid_at = 64;
    req      = 2'b01;
    beats    = 0;
    dropped  = 1'b0;
    for (int k = 1; k <= 100 && !dropped; k++) begin
      @(posedge clk); #1;
      if (mem_we) beats++;
      if (beats == 31) dropped = 1'b1;
    end
    chk("arst_reached", dropped, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_st_load", st_load, 0);
    chk("arst_mem_we", mem_we, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    v = '{2'b10, 64, 2'b10, 64, 2'b10, 1'b0, 67, 64};
    run_burst(v);

    // Randomized requesters against a phase model: phase 0 is the grant cycle,
    // phases 1..64 write words 0..63, 65 sees valid, 66 is REARM with done.
    do_reset();
    valid_at = 64;
    ph       = -1;
    owner    = 0;
    rr       = 0;
    e_done   = '0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (ph < 0) begin
        if (req != 0) begin
          found = 1'b0;
          for (int i = 0; i < NREQ; i++) begin
            j = (rr + i) % NREQ;
            if (!found && req[j]) begin
              owner = j;
              found = 1'b1;
            end
          end
          ph = 0;
        end
      end else if (ph == 66) begin
        ph = -1;
        rr = (owner + 1) % NREQ;
      end else begin
        ph++;
      end
      e_grant = (ph >= 0) ? 2'(1 << owner) : 2'b00;
      e_load  = (ph >= 0 && ph <= 65);
      e_we    = (ph >= 1 && ph <= 64);
      e_addr  = e_we ? owner * WORDS + ph - 1 : 0;
      e_done  = (ph == 66) ? 2'(1 << owner) : 2'b00;
      for (int i = 0; i < NREQ; i++) begin
        if (e_done[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 5) == 0) req[i] = 1'b1;
      end
      #1;
      chk("rnd_grant", grant, e_grant);
      chk("rnd_st_load", st_load, e_load);
      chk("rnd_mem_we", mem_we, e_we);
      chk("rnd_mem_addr", mem_addr, e_addr);
      chk("rnd_done", done, e_done);
      chk("rnd_err", err, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
